vga_timing_gen: RTL and testbench
=================================

# vga_timing_gen

Parametrised raster timing generator for the video output path, replacing the fixed 640x480 driver. It generates horizontal and vertical sync, data-enable and pixel coordinates for any mode described by its porch and sync parameters. Polarity is selectable per sync, and a pixel clock-enable allows running from a faster system clock. Sync and data-enable are delayed by a programmable number of pixel cycles so they line up with pixel data returned by a latency-bearing frame-buffer or character-ROM read addressed by the coordinates.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- HS_POL, 0, asserted level of hs (0 = active-low)
- VS_POL, 0, asserted level of vs
- PIPE_DLY, 2, pixel cycles from coordinate output to matching hs/vs/de; 0 allowed
- COORD_W, 11, coordinate and counter width
- FRAME_W, 16, frame counter width

Ports:
- clk_25mhz  in  1  pixel or system clock
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- ce  in  1  pixel enable; all state advances only on cycles with ce=1
- x_coord  out  COORD_W  active-area column, 0 outside active area
- y_coord  out  COORD_W  active-area row, 0 outside active area
- coord_valid  out  1  x/y lie inside the active area
- line_start  out  1  one-clock pulse: coordinate stage entered h=0
- frame_start  out  1  one-clock pulse: coordinate stage entered h=0, v=0
- frame_cnt  out  FRAME_W  completed-frame count, wraps
- hs  out  1  horizontal sync, polarity HS_POL
- vs  out  1  vertical sync, polarity VS_POL
- de  out  1  data enable, aligned PIPE_DLY after coord_valid

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
- Elaboration check: H_TOTAL-1 and V_TOTAL-1 fit in COORD_W.
- Horizontal counter h runs 0..H_TOTAL-1.
- Per line, h covers in order: active [0, H_ACTIVE), front porch, sync [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC), back porch.
- Vertical counter v runs 0..V_TOTAL-1 with the same ordering, and advances only when h wraps.
- h wraps H_TOTAL-1 -> 0; v wraps V_TOTAL-1 -> 0 on the same ce cycle.
- frame_cnt increments, modulo 2^FRAME_W, on the ce cycle where both counters wrap.
- Coordinate stage: registered from (h,v) on each ce cycle.
  - coord_valid = h<H_ACTIVE && v<V_ACTIVE.
  - x_coord = h when coord_valid, else 0; y_coord likewise.
- Sync stage: raw hs/vs/de are computed from the same (h,v), then passed through a PIPE_DLY-deep delay line that shifts only on ce.
- vs is asserted for whole lines, referenced to h=0; it is not half-line offset.
- ce=0: counters, coordinate registers, delay line and frame_cnt all hold; line_start and frame_start are 0.
- Reset mid-frame: all state returns to reset values immediately; the first ce after release presents h=0, v=0.

## Timing
- Reset values:
  - counters 0; x_coord, y_coord 0.
  - coord_valid, de, line_start, frame_start 0.
  - frame_cnt 0.
  - hs = ~HS_POL, vs = ~VS_POL.
  - delay-line entries hold the inactive values.
- Pulses after reset: frame_start and line_start do not pulse for the reset position. The first frame_start follows the first wrap to (0,0).
- With ce held high, position P is loaded by the edge at cycle t:
  - x_coord, y_coord, coord_valid, line_start and frame_start reflect P from cycle t+1.
  - hs, vs, de reflect P from cycle t+1+PIPE_DLY.
- With gapped ce, delays are counted in ce cycles, not clocks. Pulses last exactly one clock, the clock after the loading ce edge.
- Outputs are registered; no combinational path from ce to any output except via registers.

## Structure
- Package vga_timing_pkg holds:
  - 640x480@60 default constants.
  - functions h_total() and v_total().
  - sync-polarity localparams.
- One sub-module, vga_sync_delay: a ce-gated shift register, parameters WIDTH and DEPTH, with DEPTH=0 as a pass-through and reset to a parameterised init vector. It carries {hs, vs, de}.

## Test plan
Test mode unless stated: H 4/1/2/1 (H_TOTAL=8), V 3/1/1/1 (V_TOTAL=6), PIPE_DLY=2.
- Reset, then ce=1 for 48 cycles:
  - x_coord sequences 0,1,2,3,0,0,0,0 per line; coord_valid high 4 of 8 cycles on lines 0-2 only.
  - The cycle after the 48th ce edge shows frame_start=1 and frame_cnt=1.
- Syncs:
  - hs (active-low) is low for exactly 2 clocks per line, starting 2 clocks after coordinate stage h=5.
  - vs is low for exactly 8 clocks per frame (line 4).
- ce toggling 1,0,1,0: the same output sequences as the first scenario, stretched 2x; frame_start is a single-clock pulse; hs stays low for 4 clocks.
- HS_POL=1, VS_POL=1, PIPE_DLY=0: hs and vs are inverted relative to the defaults; de coincides with coord_valid on every cycle.
- rst_n asserted at line 2, h=3, for one cycle:
  - all outputs return to reset values in that cycle; the next ce shows x=0, y=0, coord_valid=1.
  - frame_cnt returns to 0.
- Default 640x480, 800 x 525 ce cycles: H_TOTAL=800, V_TOTAL=525, hs low 96 per line, de high 307200 per frame.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared constants, types and helpers for the raster timing generator.
package vga_timing_pkg;

    // 640x480@60 mode (25.175 MHz nominal pixel clock)
    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_H_FP     = 16;
    localparam int unsigned DEF_H_SYNC   = 96;
    localparam int unsigned DEF_H_BP     = 48;
    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_V_FP     = 10;
    localparam int unsigned DEF_V_SYNC   = 2;
    localparam int unsigned DEF_V_BP     = 33;

    // Asserted level of a sync output
    localparam bit POL_ACTIVE_LOW  = 1'b0;
    localparam bit POL_ACTIVE_HIGH = 1'b1;

    // Sync bundle carried through the alignment delay line
    typedef struct packed {
        logic hs;
        logic vs;
        logic de;
    } sync_t;

    localparam int unsigned SYNC_W = $bits(sync_t);

    function automatic int unsigned h_total(input int unsigned active, input int unsigned fp,
                                            input int unsigned sync_w, input int unsigned bp);
        return active + fp + sync_w + bp;
    endfunction

    function automatic int unsigned v_total(input int unsigned active, input int unsigned fp,
                                            input int unsigned sync_w, input int unsigned bp);
        return active + fp + sync_w + bp;
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Video timing bundle: coordinates, frame markers and delayed sync/data-enable.
interface vga_timing_gen_if #(
    parameter int COORD_W = 11,
    parameter int FRAME_W = 16
);
    logic [COORD_W-1:0] x_coord;
    logic [COORD_W-1:0] y_coord;
    logic               coord_valid;
    logic               line_start;
    logic               frame_start;
    logic [FRAME_W-1:0] frame_cnt;
    logic               hs;
    logic               vs;
    logic               de;

    modport master (
        output x_coord, y_coord, coord_valid, line_start, frame_start, frame_cnt, hs, vs, de
    );

    modport slave (
        input  x_coord, y_coord, coord_valid, line_start, frame_start, frame_cnt, hs, vs, de
    );
endinterface

// File: rtl/vga_sync_delay.sv
// Pixel-enable gated shift register that aligns sync/data-enable with pixel data.
// DEPTH=0 degenerates to a wire.
module vga_sync_delay #(
    parameter int unsigned     WIDTH = 3,
    parameter int unsigned     DEPTH = 2,
    parameter logic [WIDTH-1:0] INIT  = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ce_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] dout_o
);

    if (DEPTH == 0) begin : g_bypass
        logic unused_ok;
        assign unused_ok = ^{clk, rst_n, ce_i};
        assign dout_o    = din_i;
    end else begin : g_shift
        logic [WIDTH-1:0] stage_q [DEPTH];

        // Shift one stage per pixel enable
        // NOTE: the stages are reset (not left X) because their contents drive
        // hs/vs/de directly; a few flops of reset is cheap against a glitching sync.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int i = 0; i < DEPTH; i++) stage_q[i] <= INIT;
            end else if (ce_i) begin
                stage_q[0] <= din_i;
                for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
            end
        end

        assign dout_o = stage_q[DEPTH-1];
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator: counters, registered coordinate stage,
// and a delayed sync stage aligned to a PIPE_DLY-deep pixel fetch pipeline.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FP     = DEF_H_FP,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BP     = DEF_H_BP,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FP     = DEF_V_FP,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BP     = DEF_V_BP,
    parameter bit          HS_POL   = POL_ACTIVE_LOW,
    parameter bit          VS_POL   = POL_ACTIVE_LOW,
    parameter int unsigned PIPE_DLY = 2,
    parameter int unsigned COORD_W  = 11,
    parameter int unsigned FRAME_W  = 16
) (
    input  logic             clk_25mhz,
    input  logic             rst_n,
    input  logic             ce,
    vga_timing_gen_if.master vid
);

    localparam int unsigned H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int unsigned V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    typedef logic [COORD_W-1:0] coord_t;

    localparam coord_t H_LAST   = coord_t'(H_TOTAL - 1);
    localparam coord_t V_LAST   = coord_t'(V_TOTAL - 1);
    localparam coord_t H_ACT    = coord_t'(H_ACTIVE);
    localparam coord_t V_ACT    = coord_t'(V_ACTIVE);
    localparam coord_t HS_FIRST = coord_t'(H_ACTIVE + H_FP);
    localparam coord_t HS_LAST  = coord_t'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam coord_t VS_FIRST = coord_t'(V_ACTIVE + V_FP);
    localparam coord_t VS_LAST  = coord_t'(V_ACTIVE + V_FP + V_SYNC - 1);

    localparam sync_t SYNC_IDLE = '{hs: ~HS_POL, vs: ~VS_POL, de: 1'b0};

    if (longint'(H_TOTAL) - 1 >= (longint'(1) << COORD_W)) begin : g_h_range_err
        $error("vga_timing_gen: H_TOTAL-1 does not fit in COORD_W bits");
    end
    if (longint'(V_TOTAL) - 1 >= (longint'(1) << COORD_W)) begin : g_v_range_err
        $error("vga_timing_gen: V_TOTAL-1 does not fit in COORD_W bits");
    end

    // h_q/v_q hold the position the next pixel enable presents to the outputs.
    coord_t             h_q, h_d, v_q, v_d;
    logic               h_wrap, v_wrap;
    logic               started_q;
    logic [FRAME_W-1:0] frame_cnt_q;
    coord_t             x_q, y_q;
    logic               valid_q, line_start_q, frame_start_q;
    logic               in_active;
    sync_t              sync_raw, sync_raw_q, sync_dly;

    // Raster position advance: h wraps at end of line, v steps only on that wrap
    // NOTE: every variable gets a value before any condition so no latch is inferred.
    always_comb begin
        h_wrap = (h_q == H_LAST);
        v_wrap = (v_q == V_LAST);
        h_d    = h_wrap ? '0 : h_q + 1'b1;
        v_d    = v_q;
        if (h_wrap) v_d = v_wrap ? '0 : v_q + 1'b1;
    end

    // Region decode of the current position into active area and raw syncs
    always_comb begin
        in_active   = (h_q < H_ACT) && (v_q < V_ACT);
        sync_raw.hs = (h_q >= HS_FIRST && h_q <= HS_LAST) ? HS_POL : ~HS_POL;
        sync_raw.vs = (v_q >= VS_FIRST && v_q <= VS_LAST) ? VS_POL : ~VS_POL;
        sync_raw.de = in_active;
    end

    // Counters and completed-frame count, advancing only on pixel enable
    // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
    always_ff @(posedge clk_25mhz or negedge rst_n) begin
        if (!rst_n) begin
            h_q         <= '0;
            v_q         <= '0;
            started_q   <= 1'b0;
            frame_cnt_q <= '0;
        end else if (ce) begin
            h_q       <= h_d;
            v_q       <= v_d;
            started_q <= 1'b1;
            if (h_wrap && v_wrap) frame_cnt_q <= frame_cnt_q + 1'b1;
        end
    end

    // Coordinate stage and raw sync register; markers pulse for one clock per enable,
    // and never for the position presented straight out of reset
    always_ff @(posedge clk_25mhz or negedge rst_n) begin
        if (!rst_n) begin
            x_q           <= '0;
            y_q           <= '0;
            valid_q       <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            sync_raw_q    <= SYNC_IDLE;
        end else begin
            line_start_q  <= ce && started_q && (h_q == '0);
            frame_start_q <= ce && started_q && (h_q == '0) && (v_q == '0);
            if (ce) begin
                valid_q    <= in_active;
                x_q        <= in_active ? h_q : '0;
                y_q        <= in_active ? v_q : '0;
                sync_raw_q <= sync_raw;
            end
        end
    end

    vga_sync_delay #(
        .WIDTH (SYNC_W),
        .DEPTH (PIPE_DLY),
        .INIT  (SYNC_IDLE)
    ) u_sync_delay (
        .clk    (clk_25mhz),
        .rst_n  (rst_n),
        .ce_i   (ce),
        .din_i  (sync_raw_q),
        .dout_o (sync_dly)
    );

    assign vid.x_coord     = x_q;
    assign vid.y_coord     = y_q;
    assign vid.coord_valid = valid_q;
    assign vid.line_start  = line_start_q;
    assign vid.frame_start = frame_start_q;
    assign vid.frame_cnt   = frame_cnt_q;
    assign vid.hs          = sync_dly.hs;
    assign vid.vs          = sync_dly.vs;
    assign vid.de          = sync_dly.de;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench: three generator configurations share clock, reset and
// pixel enable; each is compared every clock against a position-index model.
module tb_vga_timing_gen;

    typedef struct {
        int ha, hfp, hsw, hbp;
        int va, vfp, vsw, vbp;
        int hpol, vpol;
        int dly;
    } mode_t;

    typedef struct {
        int x, y, cv, ls, fs, fc, hs, vs, de;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic ce = 1'b0;

    int n_checks = 0;
    int n_errors = 0;
    int k = 0;          // pixel enables accepted since the last reset
    bit last_ce = 1'b0; // the most recent edge carried a pixel enable

    mode_t mode_a, mode_b, mode_c;

    bit win_a = 1'b0, win_c = 1'b0;
    int hs_low_a = 0, vs_low_a = 0, hs_low_c = 0, de_high_c = 0;

    always #5 clk = ~clk;

    vga_timing_gen_if #(.COORD_W(11), .FRAME_W(16)) if_a ();
    vga_timing_gen_if #(.COORD_W(11), .FRAME_W(16)) if_b ();
    vga_timing_gen_if #(.COORD_W(11), .FRAME_W(16)) if_c ();

    vga_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b0), .VS_POL(1'b0), .PIPE_DLY(2), .COORD_W(11), .FRAME_W(16)
    ) dut_a (.clk_25mhz(clk), .rst_n(rst_n), .ce(ce), .vid(if_a));

    vga_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b1), .PIPE_DLY(0), .COORD_W(11), .FRAME_W(16)
    ) dut_b (.clk_25mhz(clk), .rst_n(rst_n), .ce(ce), .vid(if_b));

    vga_timing_gen dut_c (.clk_25mhz(clk), .rst_n(rst_n), .ce(ce), .vid(if_c));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s at k=%0d t=%0t: got %0d, expected %0d", tag, k, $time, obs, exp);
        end
    endtask

    // Expected outputs after k accepted enables: the n-th enable (1-based)
    // presents raster position n-1 on the coordinates, and the syncs show the
    // position presented dly enables earlier.
    function automatic exp_t model(input mode_t m, input int kk, input bit edge_ce);
        exp_t e;
        int ht, vt, p, h, v;
        ht = m.ha + m.hfp + m.hsw + m.hbp;
        vt = m.va + m.vfp + m.vsw + m.vbp;
        e.x = 0; e.y = 0; e.cv = 0; e.ls = 0; e.fs = 0; e.de = 0;
        e.hs = 1 - m.hpol;
        e.vs = 1 - m.vpol;
        e.fc = (kk / (ht * vt)) % 65536;
        if (kk > 0) begin
            p = kk - 1;
            h = p % ht;
            v = (p / ht) % vt;
            e.cv = (h < m.ha && v < m.va) ? 1 : 0;
            e.x  = e.cv ? h : 0;
            e.y  = e.cv ? v : 0;
            e.ls = (edge_ce && kk > 1 && h == 0) ? 1 : 0;
            e.fs = (e.ls && v == 0) ? 1 : 0;
        end
        if (kk > m.dly) begin
            p = kk - 1 - m.dly;
            h = p % ht;
            v = (p / ht) % vt;
            e.de = (h < m.ha && v < m.va) ? 1 : 0;
            if (h >= m.ha + m.hfp && h < m.ha + m.hfp + m.hsw) e.hs = m.hpol;
            if (v >= m.va + m.vfp && v < m.va + m.vfp + m.vsw) e.vs = m.vpol;
        end
        return e;
    endfunction

    task automatic check_dut(input string n, input mode_t m,
                             input logic [31:0] x, input logic [31:0] y, input logic [31:0] cv,
                             input logic [31:0] ls, input logic [31:0] fs, input logic [31:0] fc,
                             input logic [31:0] hs, input logic [31:0] vs, input logic [31:0] de);
        exp_t e;
        e = model(m, k, last_ce);
        check({n, ".x_coord"},     x,  e.x);
        check({n, ".y_coord"},     y,  e.y);
        check({n, ".coord_valid"}, cv, e.cv);
        check({n, ".line_start"},  ls, e.ls);
        check({n, ".frame_start"}, fs, e.fs);
        check({n, ".frame_cnt"},   fc, e.fc);
        check({n, ".hs"},          hs, e.hs);
        check({n, ".vs"},          vs, e.vs);
        check({n, ".de"},          de, e.de);
    endtask

    task automatic check_all();
        check_dut("a", mode_a, if_a.x_coord, if_a.y_coord, if_a.coord_valid, if_a.line_start,
                  if_a.frame_start, if_a.frame_cnt, if_a.hs, if_a.vs, if_a.de);
        check_dut("b", mode_b, if_b.x_coord, if_b.y_coord, if_b.coord_valid, if_b.line_start,
                  if_b.frame_start, if_b.frame_cnt, if_b.hs, if_b.vs, if_b.de);
        check_dut("c", mode_c, if_c.x_coord, if_c.y_coord, if_c.coord_valid, if_c.line_start,
                  if_c.frame_start, if_c.frame_cnt, if_c.hs, if_c.vs, if_c.de);
    endtask

    // One clock with the given pixel enable; outputs sampled 1 time unit after the edge
    task automatic tick(input bit c);
        ce = c;
        @(posedge clk);
        if (c) k++;
        last_ce = c;
        #1;
        check_all();
        if (last_ce && win_a && k >= 3 && k <= 50) begin
            if (if_a.hs == 1'b0) hs_low_a++;
            if (if_a.vs == 1'b0) vs_low_a++;
        end
        if (last_ce && win_c && k >= 3 && k <= 1602) begin
            if (if_c.hs == 1'b0) hs_low_c++;
            if (if_c.de == 1'b1) de_high_c++;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        ce = 1'b0;
        #1;
        k = 0;
        last_ce = 1'b0;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        mode_a = '{ha: 4, hfp: 1, hsw: 2, hbp: 1, va: 3, vfp: 1, vsw: 1, vbp: 1,
                   hpol: 0, vpol: 0, dly: 2};
        mode_b = '{ha: 4, hfp: 1, hsw: 2, hbp: 1, va: 3, vfp: 1, vsw: 1, vbp: 1,
                   hpol: 1, vpol: 1, dly: 0};
        mode_c = '{ha: 640, hfp: 16, hsw: 96, hbp: 48, va: 480, vfp: 10, vsw: 2, vbp: 33,
                   hpol: 0, vpol: 0, dly: 2};

        // Continuous enable through more than one small frame
        do_reset();
        win_a = 1'b1;
        repeat (60) tick(1'b1);
        win_a = 1'b0;
        check("a.hs_low_clocks_per_frame", hs_low_a, 12);
        check("a.vs_low_clocks_per_frame", vs_low_a, 8);

        // Enable on every other clock
        do_reset();
        for (int i = 0; i < 120; i++) tick(i[0] == 1'b0);

        // Random enable pattern
        do_reset();
        repeat (300) tick(1'(($urandom_range(0, 3) != 0) ? 1 : 0));

        // Reset asserted mid-frame at line 2, h=3 of the small mode (second frame)
        do_reset();
        while (k < 68) tick(1'b1);
        check("a.pre_reset_x", if_a.x_coord, 3);
        check("a.pre_reset_y", if_a.y_coord, 2);
        check("a.pre_reset_frame_cnt", if_a.frame_cnt, 1);
        #2;
        rst_n = 1'b0;
        #1;
        k = 0;
        last_ce = 1'b0;
        check_all();
        ce = 1'b1;
        @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
        tick(1'b1);
        check("a.post_reset_valid", if_a.coord_valid, 1);
        repeat (10) tick(1'b1);

        // Default 640x480 mode: two full lines of sync/data-enable
        do_reset();
        win_c = 1'b1;
        repeat (1610) tick(1'b1);
        win_c = 1'b0;
        check("c.hs_low_clocks_two_lines", hs_low_c, 192);
        check("c.de_high_clocks_two_lines", de_high_c, 1280);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
